// File: rtl/fib_seq_if.sv
// Handshake bundle for the Fibonacci-style sequence engine.
// FIB_STREAM_EN adds the per-term stream signals.
interface fib_seq_if #(
    parameter int DATA_W = 16,
    parameter int N_W    = 8
);
    logic              start;
    logic [N_W-1:0]    n;
    logic [1:0]        mode;
    logic [DATA_W-1:0] seed_a;
    logic [DATA_W-1:0] seed_b;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              ovf;
    logic [N_W-1:0]    index;
`ifdef FIB_STREAM_EN
    logic              term_valid;
    logic [DATA_W-1:0] term_data;
`endif

    modport master (
        output start, n, mode, seed_a, seed_b,
        input  busy, done, result, ovf, index
`ifdef FIB_STREAM_EN
        , input term_valid, term_data
`endif
    );

    modport slave (
        input  start, n, mode, seed_a, seed_b,
        output busy, done, result, ovf, index
`ifdef FIB_STREAM_EN
        , output term_valid, term_data
`endif
    );
endinterface

// File: rtl/fib_seq_engine.sv
// Second-order additive recurrence engine, one term per clock.
// Optional macro FIB_STREAM_EN adds a per-term output stream.
module fib_seq_engine #(
    parameter int DATA_W = 16,
    parameter int N_W    = 8
) (
    input  logic      clk,
    input  logic      rst,
    fib_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] t0;
    logic [DATA_W-1:0] t1;
    logic [N_W-1:0]    n_q;
    logic [N_W-1:0]    idx_q;
    logic [DATA_W-1:0] result_q;
    logic              ovf_q;
    logic [DATA_W:0]   sum;
    logic [N_W:0]      idx_nx;
    logic              last;
    logic              accept;

    always_comb begin
        t0 = '0;
        t1 = DATA_W'(1);
        unique case (bus.mode)
            2'b01: begin
                t0 = DATA_W'(2);
                t1 = DATA_W'(1);
            end
            2'b10: begin
                t0 = bus.seed_a;
                t1 = bus.seed_b;
            end
            default: ;
        endcase
    end

    // Compare in N_W+1 bits so n = 2^N_W-1 terminates correctly.
    assign sum    = {1'b0, x} + {1'b0, y};
    assign idx_nx = {1'b0, idx_q} + (N_W + 1)'(1);
    assign last   = idx_nx == {1'b0, n_q};
    assign accept = (state == IDLE) && bus.start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (bus.start)
                    state_nx = (bus.n <= N_W'(1)) ? DONE : CALC;
            end
            CALC: begin
                if (last) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x        <= '0;
            y        <= '0;
            n_q      <= '0;
            idx_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            n_q   <= bus.n;
            x     <= t0;
            y     <= t1;
            ovf_q <= 1'b0;
            idx_q <= N_W'(1);
            if (bus.n == '0)
                result_q <= t0;
            else if (bus.n == N_W'(1))
                result_q <= t1;
        end else if (state == CALC) begin
            x     <= y;
            y     <= sum[DATA_W-1:0];
            ovf_q <= ovf_q | sum[DATA_W];
            idx_q <= idx_nx[N_W-1:0];
            if (last) result_q <= sum[DATA_W-1:0];
        end
    end

    assign bus.busy   = state != IDLE;
    assign bus.done   = state == DONE;
    assign bus.result = result_q;
    assign bus.ovf    = ovf_q;
    assign bus.index  = idx_q;

`ifdef FIB_STREAM_EN
    logic              tv_q;
    logic [DATA_W-1:0] td_q;
    logic              pv_q;
    logic [DATA_W-1:0] pd_q;

    // One-deep pending slot lets T0 and T1 leave on separate cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tv_q <= 1'b0;
            td_q <= '0;
            pv_q <= 1'b0;
            pd_q <= '0;
        end else begin
            tv_q <= 1'b0;
            td_q <= '0;
            if (accept) begin
                tv_q <= 1'b1;
                td_q <= t0;
                pv_q <= bus.n != '0;
                pd_q <= t1;
            end else if (state == CALC) begin
                tv_q <= pv_q;
                td_q <= pv_q ? pd_q : '0;
                pv_q <= 1'b1;
                pd_q <= sum[DATA_W-1:0];
            end else if (pv_q) begin
                tv_q <= 1'b1;
                td_q <= pd_q;
                pv_q <= 1'b0;
            end
        end
    end

    assign bus.term_valid = tv_q;
    assign bus.term_data  = td_q;
`endif
endmodule
